// File: rtl/cluster_event_rx.sv
// cluster_event_rx: cluster-side receiver popping SoC events via Johnson-coded write/read tokens
module cluster_event_rx #(
   parameter int BUFFER_WIDTH = 8,
   parameter int EVNT_WIDTH   = 8,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [BUFFER_WIDTH-1:0]         events_wt_i,
   input  logic [EVNT_WIDTH-1:0]           events_da_i,
   output logic [BUFFER_WIDTH-1:0]         events_rp_o,
   output logic                            evt_valid_o,
   output logic [EVNT_WIDTH-1:0]           evt_data_o,
   input  logic                            evt_ready_i,
   output logic [$clog2(BUFFER_WIDTH):0]   fill_o,
   output logic                            err_o
);
   localparam int IW = $clog2(BUFFER_WIDTH);
   localparam int FW = IW + 1;
   localparam logic [IW-1:0] LAST = IW'(BUFFER_WIDTH - 1);

   logic [BUFFER_WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [BUFFER_WIDTH-1:0] wt_s;
   logic [IW-1:0]           ridx;
   logic [FW-1:0]           fill_d;
   logic [FW-1:0]           trans;
   logic                    empty;
   logic                    pop;
   logic                    illegal;

   // per-bit write-token synchroniser, no logic ahead of the first stage
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= events_wt_i;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   // slot occupancy, pop decision and Johnson legality of the synchronised token
   always_comb begin
      wt_s    = sync_q[SYNC_STAGES-1];
      empty   = wt_s[ridx] == events_rp_o[ridx];
      pop     = !empty && (!evt_valid_o || evt_ready_i);
      fill_d  = '0;
      trans   = '0;
      for (int i = 0; i < BUFFER_WIDTH; i++) fill_d = fill_d + FW'(wt_s[i] ^ events_rp_o[i]);
      for (int i = 0; i < BUFFER_WIDTH - 1; i++) trans = trans + FW'(wt_s[i] ^ wt_s[i+1]);
      illegal = trans > FW'(1);
   end

   // read pointer, output register, fill count and sticky error
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         events_rp_o <= '0;
         ridx        <= '0;
         evt_valid_o <= 1'b0;
         evt_data_o  <= '0;
         fill_o      <= '0;
         err_o       <= 1'b0;
      end else begin
         fill_o <= fill_d;
         err_o  <= err_o | illegal;
         if (pop) begin
            evt_data_o  <= events_da_i;
            evt_valid_o <= 1'b1;
            events_rp_o <= {events_rp_o[BUFFER_WIDTH-2:0], ~events_rp_o[BUFFER_WIDTH-1]};
            ridx        <= (ridx == LAST) ? '0 : ridx + IW'(1);
         end else if (evt_ready_i) begin
            evt_valid_o <= 1'b0;
         end
      end
   end
endmodule
